// File: rtl/bus_port_fifo_if.sv
// Host push side and bus pop side of one terminal's input FIFO.
interface bus_port_fifo_if #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8
) ();
    logic                       in_push;
    logic [pckg_sz-1:0]         in_data;
    logic                       full;
    logic [$clog2(depth+1)-1:0] count;
    logic                       pndng;
    logic                       pop;
    logic [pckg_sz-1:0]         D_pop;
    logic                       ovf;
    logic                       udf;
    logic                       self_drop;

    modport master (
        output in_push, in_data, pop,
        input  full, count, pndng, D_pop, ovf, udf, self_drop
    );
    modport slave (
        input  in_push, in_data, pop,
        output full, count, pndng, D_pop, ovf, udf, self_drop
    );
endinterface

// File: rtl/bus_port_fifo.sv
// Per-terminal input FIFO feeding the bus arbiter; self-addressed packets dropped. Stats: BUS_PORT_FIFO_STATS_EN.
// Latency: packet accepted at edge N is visible on D_pop/pndng in cycle N+1 (first-word-fall-through).
// Backpressure: none toward host; pushes into a full FIFO are lost and flagged on sticky ovf.
module bus_port_fifo #(
    parameter int         pckg_sz   = 16,
    parameter int         depth     = 8,
    parameter logic [7:0] id        = 8'h00,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    bus_port_fifo_if.slave    bus
`ifdef BUS_PORT_FIFO_STATS_EN
    ,
    output logic [15:0]       drop_cnt,
    output logic [15:0]       ovf_cnt
`endif
);
    localparam int            AW       = (depth > 1) ? $clog2(depth) : 1;
    localparam int            CW       = $clog2(depth + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(depth);

    logic [pckg_sz-1:0] mem [depth];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      cnt;
    logic               ovf_q;
    logic               udf_q;
    logic               self_drop_q;

    logic [7:0]         dest;
    logic               eligible;
    logic               valid_pop;
    logic               wr_acc;
    logic               wr_rej;

    assign dest      = bus.in_data[pckg_sz-1 -: 8];
    assign eligible  = (dest != id) || (dest == broadcast);
    assign valid_pop = bus.pop && (cnt != '0);
    // A pop on a full FIFO frees the slot the push lands in during the same edge.
    assign wr_acc    = bus.in_push && eligible && ((cnt != FULL_CNT) || valid_pop);
    assign wr_rej    = bus.in_push && eligible && (cnt == FULL_CNT) && !valid_pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            self_drop_q <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + AW'(1);
            if (valid_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (wr_acc && !valid_pop)
                cnt <= cnt + CW'(1);
            else if (valid_pop && !wr_acc)
                cnt <= cnt - CW'(1);
            if (wr_rej)
                ovf_q <= 1'b1;
            if (bus.pop && (cnt == '0))
                udf_q <= 1'b1;
            self_drop_q <= bus.in_push && !eligible;
        end
    end

    // Storage is never cleared; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (reset && wr_acc)
            mem[wr_ptr] <= bus.in_data;
    end

    assign bus.count     = cnt;
    assign bus.full      = (cnt == FULL_CNT);
    assign bus.pndng     = (cnt != '0);
    assign bus.D_pop     = (cnt != '0) ? mem[rd_ptr] : '0;
    assign bus.ovf       = ovf_q;
    assign bus.udf       = udf_q;
    assign bus.self_drop = self_drop_q;

`ifdef BUS_PORT_FIFO_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt <= '0;
            ovf_cnt  <= '0;
        end else begin
            if (bus.in_push && !eligible && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
            if (wr_rej && (ovf_cnt != 16'hFFFF))
                ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_bus_port_fifo.sv
// Randomized and directed bench for bus_port_fifo against a queue-based reference model.
module tb_bus_port_fifo;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a;
    logic reset_b;

    bus_port_fifo_if #(.pckg_sz(16), .depth(DEPTH)) ifa ();
    bus_port_fifo_if #(.pckg_sz(16), .depth(DEPTH)) ifb ();

`ifdef BUS_PORT_FIFO_STATS_EN
    logic [15:0] drop_a, ovf_a, drop_b, ovf_b;
`endif

    bus_port_fifo #(.pckg_sz(16), .depth(DEPTH), .id(8'h00), .broadcast(8'hFF)) dut_a (
        .clk(clk), .reset(reset_a), .bus(ifa)
`ifdef BUS_PORT_FIFO_STATS_EN
        , .drop_cnt(drop_a), .ovf_cnt(ovf_a)
`endif
    );

    bus_port_fifo #(.pckg_sz(16), .depth(DEPTH), .id(8'h02), .broadcast(8'hFF)) dut_b (
        .clk(clk), .reset(reset_b), .bus(ifb)
`ifdef BUS_PORT_FIFO_STATS_EN
        , .drop_cnt(drop_b), .ovf_cnt(ovf_b)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model for dut_a (id 0, broadcast FF)
    logic [15:0] mq[$];
    bit          m_ovf, m_udf, m_sd;
    int          m_drop, m_ovfc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit rst_n, input bit push, input logic [15:0] d, input bit pp);
        bit elig;
        bit vpop;
        int sz0;
        if (!rst_n) begin
            mq.delete();
            m_ovf = 0; m_udf = 0; m_sd = 0; m_drop = 0; m_ovfc = 0;
        end else begin
            elig = (d[15:8] != 8'h00) || (d[15:8] == 8'hFF);
            sz0  = mq.size();
            vpop = pp && (sz0 != 0);
            m_sd = push && !elig;
            if (push && !elig && m_drop < 65535) m_drop++;
            if (pp && sz0 == 0) m_udf = 1;
            if (vpop) void'(mq.pop_front());
            if (push && elig) begin
                if (sz0 < DEPTH || vpop) mq.push_back(d);
                else begin
                    m_ovf = 1;
                    if (m_ovfc < 65535) m_ovfc++;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [15:0] head;
        head = (mq.size() != 0) ? mq[0] : 16'h0000;
        check("count",     32'(ifa.count),     32'(mq.size()));
        check("full",      32'(ifa.full),      32'(mq.size() == DEPTH));
        check("pndng",     32'(ifa.pndng),     32'(mq.size() != 0));
        check("D_pop",     32'(ifa.D_pop),     32'(head));
        check("ovf",       32'(ifa.ovf),       32'(m_ovf));
        check("udf",       32'(ifa.udf),       32'(m_udf));
        check("self_drop", 32'(ifa.self_drop), 32'(m_sd));
`ifdef BUS_PORT_FIFO_STATS_EN
        check("drop_cnt",  32'(drop_a),        32'(m_drop));
        check("ovf_cnt",   32'(ovf_a),         32'(m_ovfc));
`endif
    endtask

    task automatic step(input bit rst_n, input bit push, input logic [15:0] d, input bit pp);
        @(negedge clk);
        reset_a     = rst_n;
        ifa.in_push = push;
        ifa.in_data = d;
        ifa.pop     = pp;
        @(posedge clk);
        model(rst_n, push, d, pp);
        #1;
        compare_all();
    endtask

    initial begin
        logic [15:0] got;
        logic [15:0] last;
        bit          seen_04ee;
        int          popk;
        int          guard;
        int          r;
        bit          rp, rq, rr;
        logic [15:0] rd;

        reset_a = 1'b0; reset_b = 1'b0;
        ifa.in_push = 1'b0; ifa.in_data = '0; ifa.pop = 1'b0;
        ifb.in_push = 1'b0; ifb.in_data = '0; ifb.pop = 1'b0;

        // Reset state
        step(0, 0, 16'h0, 0);
        step(0, 0, 16'h0, 0);
        check("rst_count", 32'(ifa.count), 0);
        check("rst_pndng", 32'(ifa.pndng), 0);
        check("rst_dpop",  32'(ifa.D_pop), 0);

        // Basic push / pop ordering
        step(1, 1, 16'h0255, 0);
        check("first_pndng", 32'(ifa.pndng), 1);
        check("first_dpop",  32'(ifa.D_pop), 32'h0255);
        step(1, 1, 16'h0311, 0);
        step(1, 1, 16'h01AA, 0);
        check("three_count", 32'(ifa.count), 3);
        check("pop1", 32'(ifa.D_pop), 32'h0255);
        step(1, 0, 16'h0, 1);
        check("pop2", 32'(ifa.D_pop), 32'h0311);
        step(1, 0, 16'h0, 1);
        check("pop3", 32'(ifa.D_pop), 32'h01AA);
        step(1, 0, 16'h0, 1);
        check("drained_pndng", 32'(ifa.pndng), 0);
        check("drained_count", 32'(ifa.count), 0);

        // Fill, overflow, then pop+push on full
        for (int i = 0; i < DEPTH; i++) step(1, 1, 16'h1000 + 16'(i), 0);
        step(1, 1, 16'h04EE, 0);
        check("ovf_full",  32'(ifa.full),  1);
        check("ovf_flag",  32'(ifa.ovf),   1);
        check("ovf_count", 32'(ifa.count), 8);
        step(1, 1, 16'h05CC, 1);
        check("full_pp_count", 32'(ifa.count), 8);
        seen_04ee = 0;
        last = '0;
        for (int i = 0; i < DEPTH; i++) begin
            got = ifa.D_pop;
            if (got == 16'h04EE) seen_04ee = 1;
            last = got;
            step(1, 0, 16'h0, 1);
        end
        check("no_04EE", 32'(seen_04ee), 0);
        check("05CC_last", 32'(last), 32'h05CC);

        // Underflow, then push+pop on empty
        step(0, 0, 16'h0, 0);
        step(1, 0, 16'h0, 1);
        check("udf_flag",  32'(ifa.udf),   1);
        check("udf_count", 32'(ifa.count), 0);
        step(1, 1, 16'h0777, 1);
        check("empty_pp_count", 32'(ifa.count), 1);
        check("empty_pp_dpop",  32'(ifa.D_pop), 32'h0777);

        // 20 packets with interleaved pops to wrap pointers
        step(0, 0, 16'h0, 0);
        popk = 0;
        for (int i = 0; i < 20; i++) begin
            got = ifa.D_pop;
            step(1, 1, 16'h3000 + 16'(i), (i >= 3));
            if (i >= 3) begin
                check("wrap_order", 32'(got), 32'(16'h3000 + 16'(popk)));
                popk++;
            end
        end
        guard = 0;
        while (popk < 20 && guard < 40) begin
            got = ifa.D_pop;
            step(1, 0, 16'h0, 1);
            check("wrap_order", 32'(got), 32'(16'h3000 + 16'(popk)));
            popk++;
            guard++;
        end
        check("wrap_all_popped", 32'(popk), 20);

        // Reset with count=5 and a push pending
        step(0, 0, 16'h0, 0);
        step(1, 0, 16'h0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, 1, 16'h4100 + 16'(i), 0);
        step(1, 1, 16'h41FF, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 16'h0, 1);
        check("pre_rst_count", 32'(ifa.count), 5);
        check("pre_rst_ovf",   32'(ifa.ovf),   1);
        check("pre_rst_udf",   32'(ifa.udf),   1);
        step(0, 1, 16'h0999, 0);
        check("rst_push_count", 32'(ifa.count), 0);
        check("rst_push_pndng", 32'(ifa.pndng), 0);
        check("rst_push_ovf",   32'(ifa.ovf),   0);
        check("rst_push_udf",   32'(ifa.udf),   0);
        step(1, 0, 16'h0, 0);
        check("rst_push_not_stored", 32'(ifa.pndng), 0);

        // Randomized traffic in phases biased toward filling and draining
        for (int ph = 0; ph < 6; ph++) begin
            for (int n = 0; n < 100; n++) begin
                r  = $urandom_range(0, 99);
                rp = (ph % 2 == 0) ? (r < 70) : (r < 30);
                rq = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 30 : 70));
                rr = ($urandom_range(0, 199) == 0);
                case ($urandom_range(0, 9))
                    0:       rd = {8'h00, 8'($urandom)};
                    1:       rd = {8'hFF, 8'($urandom)};
                    default: rd = {8'($urandom_range(1, 254)), 8'($urandom)};
                endcase
                step(!rr, rp, rd, rq);
            end
        end

        // Second instance, id=2: self filter and broadcast
        @(negedge clk);
        reset_a = 1'b1; ifa.in_push = 1'b0; ifa.pop = 1'b0;
        reset_b = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
        ifb.in_push = 1'b1;
        ifb.in_data = 16'h02AB;
        @(negedge clk);
        check("b_self_drop_pulse", 32'(ifb.self_drop), 1);
        check("b_self_count",      32'(ifb.count),     0);
        ifb.in_data = 16'hFF12;
        @(negedge clk);
        ifb.in_push = 1'b0;
        check("b_self_drop_end", 32'(ifb.self_drop), 0);
        check("b_count",         32'(ifb.count),     1);
        check("b_dpop_bcast",    32'(ifb.D_pop),     32'hFF12);
        @(negedge clk);
        check("b_self_drop_idle", 32'(ifb.self_drop), 0);
        check("b_ovf_clear",      32'(ifb.ovf),       0);
`ifdef BUS_PORT_FIFO_STATS_EN
        check("b_drop_cnt", 32'(drop_b), 1);
        check("b_ovf_cnt",  32'(ovf_b),  0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
